yo6530_bus_if: RTL and testbench

- Bus front-end of the yo6530 core; sits directly upstream of the timer, RAM, ROM and I/O port sub-blocks.
- Samples the asynchronous 6502-side bus (phi2, R/W, address, data, chip select) in the clk domain and decodes the target block.
- Issues one-clock access strobes (sel, we_n, A, DI) to that block.
- Muxes the registered sub-block read data back onto the CPU data bus with an output enable.

---
 rtl/yo6530_bus_if.sv | 188 ++++++++++++++++++
 tb/tb_yo6530_bus_if.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yo6530_bus_if.sv
// rtl/yo6530_bus_if.sv - 6502-side bus front-end of the yo6530 core
// Ports: clk, rst_n (sync, active-low); phi2, cpu_rw, cpu_addr, cpu_rs0, cpu_cs, cpu_di from the CPU;
//        cpu_do, cpu_oe back to the CPU; sel (one-hot [0] ROM [1] RAM [2] I/O [3] timer), we_n, a, di
//        strobes to the sub-blocks; rom_do, ram_do, io_do, tmr_do read data from the sub-blocks.
// Build option: YO6530_RDHOLD_EN keeps cpu_oe/cpu_do valid for HOLD_CYCLES clks after phi2 falls.
module yo6530_bus_if #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phi2,
    input  logic       cpu_rw,
    input  logic [9:0] cpu_addr,
    input  logic       cpu_rs0,
    input  logic       cpu_cs,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       cpu_oe,
    output logic [3:0] sel,
    output logic       we_n,
    output logic [9:0] a,
    output logic [7:0] di,
    input  logic [7:0] rom_do,
    input  logic [7:0] ram_do,
    input  logic [7:0] io_do,
    input  logic [7:0] tmr_do
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, DRIVE, WR, WSTB, HOLD} state_t;

    // target encoding doubles as the sel bit index
    localparam logic [1:0] T_ROM = 2'd0;
    localparam logic [1:0] T_RAM = 2'd1;
    localparam logic [1:0] T_IO  = 2'd2;
    localparam logic [1:0] T_TMR = 2'd3;

    state_t                 state, state_nx;
    logic [3:0]             cnt, cnt_nx;
    logic [1:0]             tgt, tgt_dec;
    logic [3:0]             tgt_sel;
    logic [7:0]             rd_mux;
    logic [SYNC_STAGES-1:0] sync;
    logic                   phi2_s, phi2_q, rise, fall;
    logic [2:0]             fill;
    logic                   armed;
    logic                   start, capture;

    assign phi2_s = sync[SYNC_STAGES-1];
    assign rise   = phi2_s & ~phi2_q;
    assign fall   = ~phi2_s & phi2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '0;
            phi2_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], phi2};
            phi2_q <= phi2_s;
        end
    end

    // After reset the synchronizer is full of zeros; if phi2 was still high the
    // first refill would look like a rise in the middle of an aborted cycle.
    // Accesses are only accepted once the flushed chain has shown phi2 low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill  <= 3'd0;
            armed <= 1'b0;
        end else if (fill != 3'(SYNC_STAGES)) begin
            fill <= fill + 3'd1;
        end else if (!phi2_s) begin
            armed <= 1'b1;
        end
    end

    always_comb begin
        if (cpu_rs0)          tgt_dec = T_ROM;
        else if (cpu_addr[6]) tgt_dec = T_RAM;
        else if (cpu_addr[2]) tgt_dec = T_TMR;
        else                  tgt_dec = T_IO;
    end

    always_comb begin
        case (tgt)
            T_ROM:   rd_mux = rom_do;
            T_RAM:   rd_mux = ram_do;
            T_IO:    rd_mux = io_do;
            default: rd_mux = tmr_do;
        endcase
    end

    assign tgt_sel = 4'b0001 << tgt;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel      = 4'b0000;
        we_n     = 1'b1;
        cpu_oe   = 1'b0;
        start    = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (rise && cpu_cs && armed) begin
                    start    = 1'b1;
                    state_nx = cpu_rw ? RD : WR;
                end
            end
            RD: begin
                sel      = tgt_sel;
                cnt_nx   = 4'd0;
                state_nx = fall ? IDLE : RWAIT;
            end
            RWAIT: begin
                if (fall) begin
                    state_nx = IDLE;
                end else if (cnt == 4'(RD_LAT - 1)) begin
                    capture  = 1'b1;
                    state_nx = DRIVE;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DRIVE: begin
`ifdef YO6530_RDHOLD_EN
                cpu_oe = 1'b1;
                if (fall) begin
                    if (HOLD_CYCLES > 1) begin
                        state_nx = HOLD;
                        cnt_nx   = 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
`else
                cpu_oe = ~fall;
                if (fall) state_nx = IDLE;
`endif
            end
`ifdef YO6530_RDHOLD_EN
            HOLD: begin
                cpu_oe = 1'b1;
                if (rise && cpu_cs) begin
                    start    = 1'b1;
                    state_nx = cpu_rw ? RD : WR;
                end else if (cnt == 4'(HOLD_CYCLES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
`endif
            WR: begin
                if (fall) state_nx = WSTB;
            end
            WSTB: begin
                sel      = tgt_sel;
                we_n     = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            tgt    <= T_ROM;
            a      <= '0;
            di     <= '0;
            cpu_do <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                a   <= cpu_addr;
                tgt <= tgt_dec;
            end
            // write data is only valid late in phi2, so it is taken at the fall
            if (state == WR && fall) di <= cpu_di;
            if (capture) cpu_do <= rd_mux;
        end
    end

endmodule

// File: tb/tb_yo6530_bus_if.sv
// tb/tb_yo6530_bus_if.sv - self-checking bench for yo6530_bus_if
module tb_yo6530_bus_if;

    localparam int SYNC_STAGES = 2;
    localparam int RD_LAT      = 1;
    localparam int HOLD_CYCLES = 2;
`ifdef YO6530_RDHOLD_EN
    localparam int EXP_HOLD = HOLD_CYCLES;
`else
    localparam int EXP_HOLD = 0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, phi2 = 1'b0;
    logic       cpu_rw = 1'b1, cpu_rs0 = 1'b0, cpu_cs = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic [7:0] cpu_di = '0;
    logic [7:0] rom_do = 8'h11, ram_do = 8'hA5, io_do = 8'h33, tmr_do = 8'h44;
    logic [7:0] cpu_do, cpu_do3, di, di3;
    logic       cpu_oe, cpu_oe3, we_n, we_n3;
    logic [3:0] sel, sel3;
    logic [9:0] a, a3;

    yo6530_bus_if #(.SYNC_STAGES(SYNC_STAGES), .RD_LAT(RD_LAT), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .phi2(phi2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_rs0(cpu_rs0), .cpu_cs(cpu_cs), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_oe(cpu_oe),
        .sel(sel), .we_n(we_n), .a(a), .di(di),
        .rom_do(rom_do), .ram_do(ram_do), .io_do(io_do), .tmr_do(tmr_do));

    yo6530_bus_if #(.SYNC_STAGES(SYNC_STAGES), .RD_LAT(3), .HOLD_CYCLES(HOLD_CYCLES)) dut3 (
        .clk(clk), .rst_n(rst_n), .phi2(phi2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_rs0(cpu_rs0), .cpu_cs(cpu_cs), .cpu_di(cpu_di), .cpu_do(cpu_do3), .cpu_oe(cpu_oe3),
        .sel(sel3), .we_n(we_n3), .a(a3), .di(di3),
        .rom_do(rom_do), .ram_do(ram_do), .io_do(io_do), .tmr_do(tmr_do));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int scnt = 0, r_idx = 0, f_idx = 0;
    int n_sel, sel_idx, n_bad, n_oe, oe_rise, oe_fall, n_sel3, n_oe3;
    logic [3:0] m_sel;
    logic       m_we_n, oe_prev = 1'b0;
    logic [9:0] m_a;
    logic [7:0] m_di, m_do, m_do3;

    // observer: samples 1 ns after each rising edge
    always @(posedge clk) begin
        #1;
        scnt++;
        if (sel != 4'b0000) begin
            n_sel++;
            if (n_sel == 1) begin
                sel_idx = scnt; m_sel = sel; m_we_n = we_n; m_a = a; m_di = di;
            end
        end
        if ($countones(sel) > 1 || $countones(sel3) > 1 || (!we_n && sel == 4'b0000)
            || (!we_n3 && sel3 == 4'b0000)) n_bad++;
        if (cpu_oe) begin
            n_oe++;
            m_do = cpu_do;
            if (!oe_prev && oe_rise < 0) oe_rise = scnt;
        end else if (oe_prev && oe_fall < 0) begin
            oe_fall = scnt;
        end
        oe_prev = cpu_oe;
        if (sel3 != 4'b0000) n_sel3++;
        if (cpu_oe3) begin n_oe3++; m_do3 = cpu_do3; end
    end

    task automatic clear_mon();
        n_sel = 0; sel_idx = -1; n_bad = 0; n_oe = 0; oe_rise = -1; oe_fall = -1;
        n_sel3 = 0; n_oe3 = 0; m_sel = '0; m_we_n = 1'b1; m_a = '0; m_di = '0; m_do = '0; m_do3 = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference decode and read-data selection, straight from the address map
    function automatic logic [3:0] model_sel(input logic cs, input logic rs0, input logic [9:0] ad);
        if (!cs) return 4'b0000;
        if (rs0) return 4'b0001;
        if (ad[6]) return 4'b0010;
        if (ad[2]) return 4'b1000;
        return 4'b0100;
    endfunction

    function automatic logic [7:0] model_rdata(input logic [3:0] s);
        case (s)
            4'b0001: return rom_do;
            4'b0010: return ram_do;
            4'b0100: return io_do;
            default: return tmr_do;
        endcase
    endfunction

    // one full CPU cycle: phi2 high for hi clks, then low for 12
    task automatic run_cycle(input logic cs, input logic rs0, input logic rw,
                             input logic [9:0] ad, input logic [7:0] wd, input int hi);
        @(negedge clk);
        cpu_cs = cs; cpu_rs0 = rs0; cpu_rw = rw; cpu_addr = ad; cpu_di = ~wd;
        clear_mon();
        r_idx = scnt;
        phi2 = 1'b1;
        if (hi >= 3) begin
            repeat (hi - 2) @(negedge clk);
            cpu_di = wd;
            repeat (2) @(negedge clk);
        end else begin
            repeat (hi) @(negedge clk);
        end
        f_idx = scnt;
        phi2 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic verify_cycle(input logic cs, input logic rw, input logic [9:0] ad,
                                input logic [7:0] wd, input logic [3:0] es, input logic [7:0] edo);
        check("strobe_count", n_sel, cs ? 1 : 0);
        check("dut3_strobe_count", n_sel3, cs ? 1 : 0);
        check("strobe_rules", n_bad, 0);
        if (cs) begin
            check("sel", m_sel, es);
            check("we_n", m_we_n, rw);
            check("a", m_a, ad);
            if (rw) begin
                check("rd_strobe_time", sel_idx - r_idx, SYNC_STAGES + 1);
                check("oe_rise_time", oe_rise - sel_idx, RD_LAT + 1);
                check("oe_fall_time", oe_fall - f_idx, SYNC_STAGES + EXP_HOLD);
                check("cpu_do", m_do, edo);
                check("dut3_oe_seen", n_oe3 > 0, 1);
                check("dut3_cpu_do", m_do3, edo);
            end else begin
                check("wr_strobe_time", sel_idx - f_idx, SYNC_STAGES + 1);
                check("di", m_di, wd);
                check("oe_on_write", n_oe + n_oe3, 0);
            end
        end else begin
            check("oe_deselected", n_oe + n_oe3, 0);
        end
    endtask

    typedef struct {
        logic       cs, rs0, rw;
        logic [9:0] addr;
        logic [7:0] wd;
        logic [3:0] sel;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] es;
        int tot_sel, tot_oe;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 10'h005, 8'h40, 4'b1000, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 10'h045, 8'h00, 4'b0010, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 10'h3FF, 8'h00, 4'b0001, 8'h11};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 10'h000, 8'h00, 4'b0100, 8'h33};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 10'h004, 8'h00, 4'b1000, 8'h44};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 10'h07F, 8'h5A, 4'b0010, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 10'h3B3, 8'hC3, 4'b0100, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 10'h045, 8'h00, 4'b0000, 8'h00};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 10'h0C4, 8'h96, 4'b0001, 8'h00};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 10'h004, 8'h77, 4'b0000, 8'h00};

        clear_mon();
        repeat (4) @(negedge clk);
        check("reset_cpu_do", cpu_do, 8'h00);
        check("reset_cpu_oe", cpu_oe, 1'b0);
        check("reset_sel", sel, 4'b0000);
        check("reset_we_n", we_n, 1'b1);
        check("reset_a", a, 10'h000);
        check("reset_di", di, 8'h00);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        foreach (tbl[i]) begin
            run_cycle(tbl[i].cs, tbl[i].rs0, tbl[i].rw, tbl[i].addr, tbl[i].wd, 10);
            verify_cycle(tbl[i].cs, tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].sel, tbl[i].rdata);
        end

        // reset in RWAIT, released while phi2 is still high
        @(negedge clk);
        cpu_cs = 1'b1; cpu_rs0 = 1'b0; cpu_rw = 1'b1; cpu_addr = 10'h045; ram_do = 8'hA5;
        clear_mon();
        phi2 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_cpu_oe", cpu_oe, 1'b0);
        check("midreset_sel", sel, 4'b0000);
        check("midreset_cpu_do", cpu_do, 8'h00);
        check("midreset_no_oe", n_oe + n_oe3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (6) @(negedge clk);
        phi2 = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_no_strobe", n_sel + n_sel3, 0);
        check("post_reset_no_oe", n_oe + n_oe3, 0);
        run_cycle(1'b1, 1'b0, 1'b0, 10'h004, 8'h3C, 10);
        verify_cycle(1'b1, 1'b0, 10'h004, 8'h3C, 4'b1000, 8'h00);

        // chip deselected for 10 cycles
        tot_sel = 0; tot_oe = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, i[1], i[0], 10'($urandom), 8'($urandom), 10);
            tot_sel += n_sel + n_sel3;
            tot_oe  += n_oe + n_oe3 + n_bad;
        end
        check("deselect_strobes", tot_sel, 0);
        check("deselect_oe_we", tot_oe, 0);

        // short phi2: high for 1 and 2 clks, then a sub-clk glitch
        for (int h = 1; h <= 2; h++) begin
            run_cycle(1'b1, 1'b0, 1'b1, 10'h045, 8'h00, h);
            check("short_oe", n_oe + n_oe3, 0);
            check("short_strobe_max1", n_sel <= 1 && n_sel3 <= 1, 1'b1);
            check("short_strobe_rules", n_bad, 0);
        end
        @(negedge clk);
        clear_mon();
        phi2 = 1'b1;
        #2 phi2 = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_strobe", n_sel + n_sel3 + n_oe + n_oe3, 0);
        run_cycle(1'b1, 1'b0, 1'b1, 10'h045, 8'h00, 10);
        verify_cycle(1'b1, 1'b1, 10'h045, 8'h00, 4'b0010, 8'hA5);

        // randomized cycles against the reference decode
        for (int i = 0; i < 30; i++) begin
            logic cs, rs0, rw;
            logic [9:0] ad;
            logic [7:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            rs0 = 1'($urandom); rw = 1'($urandom);
            ad = 10'($urandom); wd = 8'($urandom);
            rom_do = 8'($urandom); ram_do = 8'($urandom);
            io_do = 8'($urandom); tmr_do = 8'($urandom);
            es = model_sel(cs, rs0, ad);
            run_cycle(cs, rs0, rw, ad, wd, 10);
            verify_cycle(cs, rw, ad, wd, es, model_rdata(es));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
